// File: rtl/pipelined_signed_alu.sv
// Single-stage pipelined signed ALU with valid/ready handshake, stored carry for
// multi-word ADC/SBC, and optional saturation of signed arithmetic overflow.
module pipelined_signed_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             cout,
  output logic             carry_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_overflow;
  logic             r_negative;
  logic             r_zero;
  logic             r_cout;
  logic             r_carry_q;

  logic             w_accept;
  logic             w_invert;
  logic             w_cin;
  logic [WIDTH-1:0] w_ye;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_raw;
  logic             w_add_cout;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_res_ovf;
  logic             w_res_cout;
  logic             w_load_carry;

  assign in_ready = ~reset & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_invert = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    w_ye     = w_invert ? ~y : y;
    case (op)
      OP_SUB, OP_CMP: w_cin = 1'b1;
      OP_ADC, OP_SBC: w_cin = r_carry_q;
      default:        w_cin = 1'b0;
    endcase
    w_sum      = {1'b0, x} + {1'b0, w_ye} + {{WIDTH{1'b0}}, w_cin};
    w_raw      = w_sum[WIDTH-1:0];
    w_add_cout = w_sum[WIDTH];
    w_add_ovf  = (x[WIDTH-1] == w_ye[WIDTH-1]) && (w_raw[WIDTH-1] != x[WIDTH-1]);
  end

  // CMP reports subtraction flags but passes x through and never saturates.
  always_comb begin
    w_res        = w_raw;
    w_res_ovf    = 1'b0;
    w_res_cout   = 1'b0;
    w_load_carry = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_res_ovf    = w_add_ovf;
        w_res_cout   = w_add_cout;
        w_load_carry = 1'b1;
        if (SATURATE && w_add_ovf) begin
          w_res = x[WIDTH-1] ? MIN_NEG : MAX_POS;
        end else begin
          w_res = w_raw;
        end
      end
      OP_AND: w_res = x & y;
      OP_OR:  w_res = x | y;
      OP_XOR: w_res = x ^ y;
      OP_CMP: begin
        w_res      = x;
        w_res_ovf  = w_add_ovf;
        w_res_cout = w_add_cout;
      end
      default: w_res = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_s         <= {WIDTH{1'b0}};
      r_overflow  <= 1'b0;
      r_negative  <= 1'b0;
      r_zero      <= 1'b1;
      r_cout      <= 1'b0;
      r_carry_q   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_s         <= w_res;
      r_overflow  <= w_res_ovf;
      r_negative  <= w_res[WIDTH-1];
      r_zero      <= (w_res == {WIDTH{1'b0}});
      r_cout      <= w_res_cout;
      if (w_load_carry) begin
        r_carry_q <= w_add_cout;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign overflow  = r_overflow;
  assign negative  = r_negative;
  assign zero      = r_zero;
  assign cout      = r_cout;
  assign carry_q   = r_carry_q;

endmodule

// File: tb/tb_pipelined_signed_alu.sv
// Scoreboard bench: directed vectors push hand-computed results; a negedge monitor
// pops and compares on every consumed output. Instance b runs with SATURATE=1.
module tb_pipelined_signed_alu;

  typedef struct packed {
    logic [7:0] s;
    logic       ovf;
    logic       neg;
    logic       zero;
    logic       cout;
    logic       cq;
  } exp_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] ADC = 3'b010;
  localparam logic [2:0] SBC = 3'b011;
  localparam logic [2:0] AND = 3'b100;
  localparam logic [2:0] OR  = 3'b101;
  localparam logic [2:0] XOR = 3'b110;
  localparam logic [2:0] CMP = 3'b111;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       iv_a = 1'b0;
  logic       iv_b = 1'b0;
  logic       ordy = 1'b1;
  logic [2:0] op   = 3'b000;
  logic [7:0] x    = 8'h00;
  logic [7:0] y    = 8'h00;

  logic       rdy_a, ov_a, ovf_a, neg_a, zero_a, cout_a, cq_a;
  logic [7:0] s_a;
  logic       rdy_b, ov_b, ovf_b, neg_b, zero_b, cout_b, cq_b;
  logic [7:0] s_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   na = 0;
  int   nb = 0;

  always #5 clk = ~clk;

  pipelined_signed_alu #(.WIDTH(8), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(rst), .in_valid(iv_a), .in_ready(rdy_a), .op(op), .x(x), .y(y),
    .out_valid(ov_a), .out_ready(ordy), .s(s_a), .overflow(ovf_a), .negative(neg_a),
    .zero(zero_a), .cout(cout_a), .carry_q(cq_a)
  );

  pipelined_signed_alu #(.WIDTH(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(rst), .in_valid(iv_b), .in_ready(rdy_b), .op(op), .x(x), .y(y),
    .out_valid(ov_b), .out_ready(ordy), .s(s_b), .overflow(ovf_b), .negative(neg_b),
    .zero(zero_b), .cout(cout_b), .carry_q(cq_b)
  );

  function automatic exp_t mk(input logic [7:0] s, input logic o, input logic n,
                              input logic z, input logic c, input logic q);
    exp_t e;
    e = {s, o, n, z, c, q};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every consumed output is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && ov_a === 1'b1 && ordy === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_a got=s:%h exp=no_output", s_a);
      end else begin
        e = qa.pop_front();
        chk($sformatf("res_a%0d", na), {19'd0, s_a, ovf_a, neg_a, zero_a, cout_a, cq_a}, {19'd0, e});
        na++;
      end
    end
    if (rst === 1'b0 && ov_b === 1'b1 && ordy === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b got=s:%h exp=no_output", s_b);
      end else begin
        e = qb.pop_front();
        chk($sformatf("res_b%0d", nb), {19'd0, s_b, ovf_b, neg_b, zero_b, cout_b, cq_b}, {19'd0, e});
        nb++;
      end
    end
  end

  task automatic issue(input bit d, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, input bit push, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    op = o;
    x  = a;
    y  = b;
    if (d) iv_b = 1'b1;
    else   iv_a = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if ((d ? rdy_b : rdy_a) === 1'b1) begin
        done = 1'b1;
        if (push) begin
          if (d) qb.push_back(e);
          else   qa.push_back(e);
        end
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic run(input bit d, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                     input exp_t e);
    int w;
    issue(d, o, a, b, e, 1'b1, w);
  endtask

  task automatic drain();
    ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reset lands the cycle after an accept whose result is still unconsumed.
  task automatic rst_test(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int w;
    ordy = 1'b0;
    issue(1'b0, o, a, b, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, w);
    rst  = 1'b1;
    ordy = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_state", {18'd0, ov_a, s_a, ovf_a, neg_a, zero_a, cout_a, cq_a},
        {18'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {17'd0, rdy_a, ov_a, s_a, ovf_a, neg_a, zero_a, cout_a, cq_a},
        {17'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("reset_b", {17'd0, rdy_b, ov_b, s_b, ovf_b, neg_b, zero_b, cout_b, cq_b},
        {17'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;

    // mk(s, overflow, negative, zero, cout, carry_q)
    run(1'b0, ADD, 8'h7F, 8'h01, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    run(1'b0, SUB, 8'h05, 8'h05, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    run(1'b0, ADD, 8'hFF, 8'h01, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    run(1'b0, ADC, 8'h00, 8'h00, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(1'b0, SBC, 8'h10, 8'h01, mk(8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    run(1'b0, SBC, 8'h10, 8'h01, mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    run(1'b0, AND, 8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    run(1'b0, OR,  8'h0F, 8'h30, mk(8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    run(1'b0, XOR, 8'hFF, 8'hFF, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    run(1'b0, CMP, 8'h03, 8'h05, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    run(1'b0, CMP, 8'h80, 8'h01, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    run(1'b0, SUB, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    run(1'b0, SUB, 8'h00, 8'h01, mk(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    run(1'b1, ADD, 8'h80, 8'hFF, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    run(1'b1, SUB, 8'h7F, 8'hFF, mk(8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run(1'b1, ADD, 8'h01, 8'h02, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(1'b1, CMP, 8'h80, 8'h01, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    run(1'b1, ADC, 8'h7F, 8'h01, mk(8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run(1'b1, SBC, 8'h80, 8'h01, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    ordy = 1'b0;
    issue(1'b0, ADD, 8'h01, 8'h02, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {22'd0, rdy_a, ov_a, s_a}, {22'd0, 1'b0, 1'b1, 8'h03});
    end
    @(posedge clk);
    #1;
    ordy = 1'b1;
    issue(1'b0, ADD, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    chk("bp_no_bubble", w, 32'd0);
    chk("bp_load", {23'd0, ov_a, s_a}, {23'd0, 1'b1, 8'h30});
    drain();

    rst_test(ADD, 8'h01, 8'h01);
    rst_test(SUB, 8'h05, 8'h05);
    ordy = 1'b1;
    run(1'b0, ADD, 8'h01, 8'h01, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_signed_alu.md
PIPELINED_SIGNED_ALU -- requirements
Module: pipelined_signed_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal values are 2 or greater.
REQ-002 Parameter SATURATE, default 0: when 1, signed arithmetic results clamp on overflow; when 0, they wrap.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high.
REQ-004 Ports SHALL be, in order (name  direction  width  meaning):
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request presented.
- in_ready  output  1  block can accept a request this cycle.
- op  input  3  operation select.
- x  input  WIDTH  operand A, two's complement.
- y  input  WIDTH  operand B, two's complement.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- s  output  WIDTH  result.
- overflow  output  1  signed overflow flag.
- negative  output  1  s[WIDTH-1].
- zero  output  1  s is all zeros.
- cout  output  1  carry out of the adder.
- carry_q  output  1  stored carry used by ADC and SBC.

Function
REQ-005 Opcodes SHALL be:
- 000 ADD: x+y
- 001 SUB: x+~y+1
- 010 ADC: x+y+carry_q
- 011 SBC: x+~y+carry_q
- 100 AND
- 101 OR
- 110 XOR
- 111 CMP: SUB flags, with s=x
REQ-006 Handshake and latency:
- accept = in_valid & in_ready.
- in_ready = ~reset & (~out_valid | out_ready).
- The result SHALL appear on the outputs 1 cycle after accept.
REQ-007 out_valid update on each clock edge:
- set on accept;
- cleared when out_valid & out_ready with no accept in the same cycle;
- a simultaneous consume and accept SHALL keep out_valid=1 and load the new result (full throughput).
REQ-008 While out_valid=1 and out_ready=0, s and all flags SHALL hold stable and no request is accepted.
REQ-009 Adder arithmetic:
- ye = ~y for SUB, SBC and CMP; ye = y otherwise.
- {cout, raw} = x + ye + cin, computed at WIDTH+1 bits.
- cin = 1 for SUB and CMP, carry_q for ADC and SBC, 0 for ADD.
REQ-010 overflow = (x[MSB] == ye[MSB]) & (raw[MSB] != x[MSB]), evaluated for arithmetic ops and CMP.
REQ-011 Saturation: when SATURATE=1 and overflow=1 on ADD, SUB, ADC or SBC:
- s SHALL be 0111...1 if x[MSB]=0, else 1000...0;
- overflow SHALL remain 1;
- cout SHALL be the raw adder carry.
REQ-012 negative and zero SHALL be derived from the final registered s, after any saturation and including CMP (where s=x).
REQ-013 Logic ops SHALL produce cout=0 and overflow=0.
REQ-014 carry_q SHALL load cout on accept of ADD, SUB, ADC or SBC; CMP and logic ops SHALL leave it unchanged.
REQ-015 SUB carry convention: cout=1 means no borrow.

Reset
REQ-016 While reset=1 at a clock edge, the registers SHALL load:
- out_valid=0, s=0;
- overflow=0, negative=0, cout=0, carry_q=0;
- zero=1, consistent with s=0.
REQ-017 Reset SHALL override any simultaneous accept or consume; a pending unconsumed result is discarded.
REQ-018 in_ready SHALL be 0 while reset=1.

Verification (WIDTH=8 unless stated)
REQ-019 ADD x=0x7F, y=0x01, SATURATE=0 -> s=0x80, overflow=1, negative=1, zero=0, cout=0.
REQ-020 SUB x=0x05, y=0x05 -> s=0x00, zero=1, cout=1, overflow=0, carry_q=1.
REQ-021 Multi-word: ADD x=0xFF, y=0x01 -> s=0x00, cout=1; then ADC x=0x00, y=0x00 -> s=0x01, carry_q=0.
REQ-022 SATURATE=1:
- ADD x=0x80, y=0xFF -> s=0x80, overflow=1;
- SUB x=0x7F, y=0xFF -> s=0x7F, overflow=1.
REQ-023 Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0, s stable for 5 cycles; then assert out_ready with in_valid=1 -> next result loads with no bubble cycle.
REQ-024 Reset asserted the cycle after an accept of ADD 0x01+0x01 -> out_valid=0, s=0x00, zero=1, carry_q=0; the first accept after reset deasserts behaves normally.
